// File: rtl/fp16_pair_packer.sv
// Packs a stream of fp16 halves into 32-bit words, two halves per word, lower lane first.
// A packet ending on an odd half emits a final word with only the lower lane enabled.
module fp16_pair_packer #(
  parameter int CANON_NAN = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic [1:0]       out_keep,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             nan_seen
);

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] QNAN = 16'h7E00;

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  function automatic logic is_nan(input logic [DATA_W-1:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h000);
  endfunction

  function automatic logic [DATA_W-1:0] canon_half(input logic [DATA_W-1:0] h);
    if ((CANON_NAN != 0) && is_nan(h)) return QNAN;
    return h;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_W-1:0]     r_hold_p0;
  logic [2*DATA_W-1:0]   r_data_p1;
  logic [1:0]            r_keep_p1;
  logic                  r_last_p1;
  logic                  r_vld_p1;
  logic [CNT_W-1:0]      r_word_cnt;
  logic                  r_nan_seen;

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_is_nan;
  logic [DATA_W-1:0]     w_half;
  logic                  w_hold_en;
  logic                  w_load;
  logic [2*DATA_W-1:0]   w_ld_data;
  logic [1:0]            w_ld_keep;
  logic                  w_ld_last;

  // Ready only looks at the output register, so a stalled word blocks new halves
  // and a draining word lets one in on the same edge.
  assign in_ready   = !r_vld_p1 || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_vld_p1 && out_ready;
  assign w_is_nan   = is_nan(in_data);
  assign w_half     = canon_half(in_data);

  always_comb begin
    w_state_nxt = r_state;
    w_hold_en   = 1'b0;
    w_load      = 1'b0;
    w_ld_data   = '0;
    w_ld_keep   = 2'b00;
    w_ld_last   = 1'b0;
    if (w_in_xfer) begin
      case (r_state)
        ST_LO: begin
          if (in_last) begin
            w_load    = 1'b1;
            w_ld_data = {16'h0000, w_half};
            w_ld_keep = 2'b01;
            w_ld_last = 1'b1;
          end else begin
            w_hold_en   = 1'b1;
            w_state_nxt = ST_HI;
          end
        end
        ST_HI: begin
          w_load      = 1'b1;
          w_ld_data   = {w_half, r_hold_p0};
          w_ld_keep   = 2'b11;
          w_ld_last   = in_last;
          w_state_nxt = ST_LO;
        end
        default: w_state_nxt = ST_LO;
      endcase
    end
  end

  // p0: lower-half hold; p1: output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_LO;
      r_hold_p0  <= '0;
      r_data_p1  <= '0;
      r_keep_p1  <= 2'b00;
      r_last_p1  <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_word_cnt <= '0;
      r_nan_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_en) r_hold_p0 <= w_half;
      if (w_load) begin
        r_data_p1 <= w_ld_data;
        r_keep_p1 <= w_ld_keep;
        r_last_p1 <= w_ld_last;
        r_vld_p1  <= 1'b1;
      end else if (w_out_xfer) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_out_xfer) r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_in_xfer && w_is_nan) r_nan_seen <= 1'b1;
    end
  end

  assign out_valid  = r_vld_p1;
  assign out_data   = r_data_p1;
  assign out_keep   = r_keep_p1;
  assign out_last   = r_last_p1;
  assign word_count = r_word_cnt;
  assign nan_seen   = r_nan_seen;

endmodule

// File: doc/fp16_pair_packer.md
FP16_PAIR_PACKER -- requirements
Module: fp16_pair_packer

Interface
REQ-001 SHALL provide parameter CANON_NAN, default 0: when 1, every accepted NaN half is replaced by canonical 16'h7E00 before packing.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the output word counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream fp16 half-precision value valid.
REQ-006 in_data  input  16  fp16 value from the fp32-to-fp16 converter stage.
REQ-007 in_last  input  1  marks final half of a packet; qualified by in_valid.
REQ-008 in_ready  output  1  packer can accept in_data this cycle.
REQ-009 out_valid  output  1  out_data/out_keep/out_last valid.
REQ-010 out_data  output  32  packed word; [15:0] earlier half, [31:16] later half.
REQ-011 out_keep  output  2  lane enables; 2'b11 full word, 2'b01 lower lane only.
REQ-012 out_last  output  1  word ends a packet.
REQ-013 out_ready  input  1  downstream accepts word this cycle.
REQ-014 word_count  output  CNT_W  count of output words transferred since reset.
REQ-015 nan_seen  output  1  sticky flag: at least one NaN half accepted since reset.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), with no combinational dependence on in_valid, in_data or in_last.
REQ-018 out_valid SHALL not depend combinationally on out_ready; once asserted, out_data/out_keep/out_last SHALL hold stable until transfer.
REQ-019 FSM SHALL have two states: LO (no half held), HI (lower half held in hold register).
REQ-020 LO, input transfer, in_last=0: SHALL store half in hold register and go to HI; no output word produced.
REQ-021 LO, input transfer, in_last=1: SHALL load output register next cycle with {16'h0000, half}, keep=2'b01, last=1; stay LO.
REQ-022 HI, input transfer: SHALL load output register next cycle with {half, hold}, keep=2'b11, last=in_last; go to LO.
REQ-023 Output register SHALL reload in the same cycle as an output transfer when a word-producing input transfer coincides, sustaining one input per cycle.
REQ-024 out_valid SHALL deassert after output transfer when no new word is loaded in that cycle.
REQ-025 NaN SHALL be detected as in_data[14:10]==5'h1F && in_data[9:0]!=0; infinities SHALL not count as NaN.
REQ-026 With CANON_NAN=1 the sign bit of a NaN SHALL also be replaced (result exactly 16'h7E00); with CANON_NAN=0 data SHALL pass bit-exact.
REQ-027 nan_seen SHALL set on the cycle after any NaN input transfer and remain set until reset.
REQ-028 word_count SHALL increment by 1 per output transfer and wrap from all-ones to zero.
REQ-029 Single-cycle latency: word available (out_valid=1) on the cycle after its completing input transfer.
REQ-030 No output word SHALL exist while in HI except a previously completed one; a held lower half SHALL never be emitted without a second half or in_last.

Reset
REQ-031 While rst=1 on a clock edge: state=LO, out_valid=0, out_data=0, out_keep=0, out_last=0, word_count=0, nan_seen=0, hold register=0.
REQ-032 Reset mid-operation SHALL discard a held lower half and any pending unaccepted output word; in_ready SHALL read 1 in the first cycle after reset.

Verification
REQ-033 Halves 16'h3C00, 16'h4000 (last=0) streamed, out_ready=1 -> one word 32'h40003C00, keep=11, last=0, word_count=1.
REQ-034 Single half 16'hC500 with in_last=1 from LO -> word 32'h0000C500, keep=01, last=1.
REQ-035 Three halves A,B,C (C last), continuous valid -> words {B,A} keep=11 then {0,C} keep=01 last=1; in_ready stays 1 throughout.
REQ-036 out_ready=0 for 5 cycles with word pending -> in_ready=0, out_data stable; on release word transfers and next half accepted same cycle.
REQ-037 CANON_NAN=1, input 16'hFD01 then 16'h7C00 -> word 32'h7C007E00, nan_seen=1 (infinity alone keeps nan_seen=0).
REQ-038 rst asserted while in HI holding 16'h1234 -> after reset next two halves 16'h0001, 16'h0002 yield 32'h00020001, no trace of 16'h1234.
